// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding, sizes and CLA group helper for the shift-add multiplier
package mult_pkg;
  localparam int MULT_WIDTH = 16;
  localparam int MULT_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // 4-bit carry-lookahead group: returns {carry_out, sum}
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], p ^ c[3:0]};
  endfunction
endpackage

// File: rtl/add16_csel.sv
// rtl/add16_csel.sv - combinational 16-bit carry-select adder from 4-bit CLA groups
module add16_csel
  import mult_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] y,
  output logic        cout
);
  logic [4:0] grp0;
  logic [4:0] r0 [1:3];
  logic [4:0] r1 [1:3];
  logic [4:0] sel [1:3];
  logic [4:1] c;

  assign grp0    = cla4(a[3:0], b[3:0], cin);
  assign y[3:0]  = grp0[3:0];
  assign c[1]    = grp0[4];

  // Upper groups precompute both carry-in cases; the ripple is only through the muxes
  for (genvar gi = 1; gi < 4; gi++) begin : g_sel
    assign r0[gi]            = cla4(a[4*gi+3 -: 4], b[4*gi+3 -: 4], 1'b0);
    assign r1[gi]            = cla4(a[4*gi+3 -: 4], b[4*gi+3 -: 4], 1'b1);
    assign sel[gi]           = c[gi] ? r1[gi] : r0[gi];
    assign y[4*gi+3 -: 4]    = sel[gi][3:0];
    assign c[gi+1]           = sel[gi][4];
  end

  assign cout = c[4];
endmodule

// File: rtl/shift_add_mult16.sv
// rtl/shift_add_mult16.sv - iterative radix-2 shift-add 16x16 unsigned multiplier
module shift_add_mult16
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum;
  logic               cout;

  add16_csel u_add (
    .a   (a_q),
    .b   (m_q),
    .cin (1'b0),
    .y   (sum),
    .cout(cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    product   = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          m_d     = a;
          q_d     = b;
          a_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The shift always leaves C clear, so {C,A,Q} zero-fills on the no-add path
        if (q_q[0]) {c_d, a_d, q_d} = {cout, sum, q_q} >> 1;
        else        {c_d, a_d, q_d} = {c_q, a_q, q_q} >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        product   = {a_q, q_q};
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_shift_add_mult16.sv
// tb/tb_shift_add_mult16.sv - self-checking bench for shift_add_mult16
module tb_shift_add_mult16;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  shift_add_mult16 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product)
  );

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input int hold,
                        input bit scramble, input logic [31:0] exp, input string tag);
    int          lat;
    logic [31:0] held;
    check({tag, "/in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "/in_ready_run"}, {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (scramble) begin
        a        = 16'($urandom);
        b        = 16'($urandom);
        in_valid = 1'b1;
        out_ready = 1'b1;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'd16);
    check({tag, "/product"}, product, exp);
    held = product;
    repeat (hold) begin
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, "/hold_product"}, product, held);
      check({tag, "/hold_valid"}, {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/idle_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "/idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "/idle_product"}, product, 32'd0);
  endtask

  initial begin
    int          cyc;
    int          last_acc;
    int          got;
    int          lat;
    logic [31:0] e;
    vec_t        v;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    check("reset/in_ready", {31'd0, in_ready}, 32'd1);
    check("reset/out_valid", {31'd0, out_valid}, 32'd0);
    check("reset/product", product, 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_out_ready/in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_out_ready/out_valid", {31'd0, out_valid}, 32'd0);

    vecs.push_back('{16'h0003, 16'h0005, 32'h0000000F});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 32'hFFFE0001});
    vecs.push_back('{16'h8000, 16'h0002, 32'h00010000});
    vecs.push_back('{16'h0000, 16'h1234, 32'h00000000});
    vecs.push_back('{16'hFFFF, 16'h0001, 32'h0000FFFF});
    vecs.push_back('{16'h0001, 16'h8000, 32'h00008000});
    for (int i = 0; i < 8; i++) begin
      v.a   = 16'($urandom);
      v.b   = 16'($urandom);
      v.exp = ref_mul(v.a, v.b);
      vecs.push_back(v);
    end
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].a, vecs[i].b, 0, i[0], vecs[i].exp, $sformatf("vec%0d", i));

    run_op(16'h1234, 16'h5678, 5, 1'b1, 32'h06260060, "hold5");

    // Reset in RUN with cnt==7
    a        = 16'hABCD;
    b        = 16'h0101;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_run/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_run/product", product, 32'd0);
    check("rst_run/in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0007, 16'h0009, 0, 1'b0, 32'h0000003F, "after_rst");

    // Reset while the product is waiting in DONE must drop out_valid asynchronously
    a        = 16'h0102;
    b        = 16'h0304;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("rst_done/valid_before", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_done/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done/product", product, 32'd0);
    check("rst_done/in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back with in_valid held and out_ready tied high
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 16'($urandom);
    b         = 16'($urandom);
    cyc       = 0;
    last_acc  = -1;
    got       = 0;
    while (got < 5 && cyc < 200) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b/unexpected_product", product, 32'hDEADBEEF);
        end else begin
          e = exp_q.pop_front();
          check("b2b/product", product, e);
        end
        got++;
      end
      if (in_ready) begin
        if (last_acc >= 0) check("b2b/accept_gap", 32'(cyc - last_acc), 32'd18);
        last_acc = cyc;
        exp_q.push_back(ref_mul(a, b));
      end else begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b/products_seen", 32'(got), 32'd5);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
